// File: rtl/mips_ctl_pkg.sv
// rtl/mips_ctl_pkg.sv - shared encodings for the multi-cycle sequencing controller
package mips_ctl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RD2 = 2'b00;
  localparam logic [1:0] SRCB_TWO = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_SLT: op_is_legal = 1'b1;
      default:                                        op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - opcode to ALU operation / operand-type decode
module alu_decode
  import mips_ctl_pkg::*;
(
  input  logic [3:0] op,
  output logic [2:0] alu_ctl,
  output logic       is_imm,
  output logic       legal
);

  always_comb begin
    alu_ctl = ALU_AND;
    is_imm  = 1'b0;
    legal   = 1'b1;
    case (op)
      OP_ADD:  alu_ctl = ALU_ADD;
      OP_SUB:  alu_ctl = ALU_SUB;
      OP_AND:  alu_ctl = ALU_AND;
      OP_OR:   alu_ctl = ALU_OR;
      OP_ADDI: begin
        alu_ctl = ALU_ADD;
        is_imm  = 1'b1;
      end
      OP_SLT:  alu_ctl = ALU_SLT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - FETCH/DECODE/EXEC/WB sequencer sharing one ALU
module multicycle_control
  import mips_ctl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             run,
  input  logic [3:0]       op,
  input  logic             imem_ack,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctl,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       dec_ctl;
  logic             dec_imm;
  logic             dec_legal;

  alu_decode u_alu_decode (
    .op      (op_q),
    .alu_ctl (dec_ctl),
    .is_imm  (dec_imm),
    .legal   (dec_legal)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      op_q      <= 4'd0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      // IR is valid from DECODE on; later changes on op are ignored
      if (state_q == S_DECODE) begin
        op_q <= op;
        if (!op_is_legal(op)) illegal_q <= 1'b1;
      end
      if (state_q == S_WB) cnt_q <= cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RD2;
    alu_ctl   = ALU_AND;
    reg_dst   = 1'b0;
    reg_write = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        imem_req  = 1'b1;
        alu_src_b = SRCB_TWO;
        alu_ctl   = ALU_ADD;
        if (imem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: state_d = op_is_legal(op) ? S_EXEC : S_TRAP;
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = dec_imm ? SRCB_IMM : SRCB_RD2;
        alu_ctl   = dec_ctl;
        state_d   = S_WB;
      end
      // ALU operands held from EXEC so the write-back value stays stable
      S_WB: begin
        alu_src_a = 1'b1;
        alu_src_b = dec_imm ? SRCB_IMM : SRCB_RD2;
        alu_ctl   = dec_ctl;
        reg_write = dec_legal;
        reg_dst   = ~dec_imm;
        state_d   = run ? S_FETCH : S_IDLE;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  assign illegal     = illegal_q;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  logic        clock;
  logic        resetn;
  logic        run;
  logic [3:0]  op;
  logic        imem_ack;
  logic        imem_req;
  logic        ir_write;
  logic        pc_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_ctl;
  logic        reg_dst;
  logic        reg_write;
  logic        illegal;
  logic [2:0]  state;
  logic [15:0] instr_count;

  multicycle_control #(.CNT_W(16)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .run         (run),
    .op          (op),
    .imem_ack    (imem_ack),
    .imem_req    (imem_req),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_ctl     (alu_ctl),
    .reg_dst     (reg_dst),
    .reg_write   (reg_write),
    .illegal     (illegal),
    .state       (state),
    .instr_count (instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [14:0] v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [14:0] obs;
  assign obs = {state, imem_req, ir_write, pc_write, alu_src_a, alu_src_b,
                alu_ctl, reg_dst, reg_write, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] mk(input logic [2:0] st, input logic req, input logic irw,
                                     input logic pcw, input logic srca, input logic [1:0] srcb,
                                     input logic [2:0] ctl, input logic dst, input logic rw,
                                     input logic ill);
    return {st, req, irw, pcw, srca, srcb, ctl, dst, rw, ill};
  endfunction

  function automatic logic [14:0] e_idle();
    return 15'd0;
  endfunction
  function automatic logic [14:0] e_fetch(input logic ack);
    return mk(3'd1, 1'b1, ack, ack, 1'b0, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [14:0] e_dec();
    return mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [14:0] e_exec(input logic [2:0] ctl, input logic imm);
    return mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b1, imm ? 2'b10 : 2'b00, ctl, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [14:0] e_wb(input logic [2:0] ctl, input logic imm);
    return mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, imm ? 2'b10 : 2'b00, ctl, ~imm, 1'b1, 1'b0);
  endfunction
  function automatic logic [14:0] e_trap();
    return mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1);
  endfunction

  always @(negedge clock) begin
    while (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      check(x.tag, {17'd0, obs}, {17'd0, x.v});
    end
  end

  // Push the expectation for the current cycle, then advance to just after the next edge
  task automatic step(input string tag, input logic [14:0] v);
    q.push_back('{tag, v});
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    resetn = 1'b0;
    #1;
    check({tag, "_ctl"}, {17'd0, obs}, 32'd0);
    check({tag, "_cnt"}, {16'd0, instr_count}, 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  // Entered with the FSM in FETCH; run_wb is the run level seen from EXEC onward
  task automatic run_instr(input string tag, input logic [3:0] op_val, input int delay,
                           input logic [2:0] ctl, input logic imm, input logic run_wb);
    op = op_val;
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0;
      step({tag, "_fetchwait"}, e_fetch(1'b0));
    end
    imem_ack = 1'b1;
    step({tag, "_fetch"}, e_fetch(1'b1));
    step({tag, "_decode"}, e_dec());
    op  = 4'($urandom_range(0, 15));
    run = run_wb;
    step({tag, "_exec"}, e_exec(ctl, imm));
    step({tag, "_wb"}, e_wb(ctl, imm));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  logic [3:0] seq_op  [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111};
  logic [2:0] seq_ctl [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  initial begin
    resetn   = 1'b0;
    run      = 1'b0;
    op       = 4'd0;
    imem_ack = 1'b0;
    #3;
    check("por_ctl", {17'd0, obs}, 32'd0);
    check("por_cnt", {16'd0, instr_count}, 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;

    // ADDI with ack tied high
    run      = 1'b1;
    imem_ack = 1'b1;
    step("addi_idle", e_idle());
    run_instr("addi", 4'b0100, 0, 3'b010, 1'b1, 1'b1);
    check("addi_cnt", {16'd0, instr_count}, 32'd1);
    step("addi_next_fetch", e_fetch(1'b1));
    apply_reset("rst1");

    // R-type sequence back to back
    run = 1'b1;
    step("seq_idle", e_idle());
    for (int i = 0; i < 5; i++) run_instr($sformatf("seq%0d", i), seq_op[i], 0, seq_ctl[i], 1'b0, 1'b1);
    check("seq_cnt", {16'd0, instr_count}, 32'd5);
    apply_reset("rst2");

    // delayed ack, run dropped while waiting in FETCH
    run = 1'b1;
    step("dly_idle", e_idle());
    run = 1'b0;
    run_instr("dly", 4'b0000, 3, 3'b010, 1'b0, 1'b0);
    check("dly_cnt", {16'd0, instr_count}, 32'd1);
    imem_ack = 1'b1;
    step("dly_idle_after", e_idle());
    apply_reset("rst3");

    // illegal opcode traps until reset
    run      = 1'b1;
    imem_ack = 1'b1;
    op       = 4'b1010;
    step("trap_idle", e_idle());
    step("trap_fetch", e_fetch(1'b1));
    step("trap_decode", e_dec());
    for (int i = 0; i < 4; i++) step($sformatf("trap_hold%0d", i), e_trap());
    check("trap_cnt", {16'd0, instr_count}, 32'd0);
    apply_reset("rst_trap");

    // run dropped in EXEC
    run = 1'b1;
    step("drop_idle", e_idle());
    run_instr("drop", 4'b0001, 0, 3'b110, 1'b0, 1'b0);
    check("drop_cnt", {16'd0, instr_count}, 32'd1);
    step("drop_idle0", e_idle());
    step("drop_idle1", e_idle());
    run = 1'b1;
    imem_ack = 1'b0;
    step("drop_restart_idle", e_idle());
    step("drop_refetch", e_fetch(1'b0));
    apply_reset("rst4");

    // counter wrap
    force dut.cnt_q = 16'hffff;
    #1;
    release dut.cnt_q;
    run = 1'b1;
    step("wrap_idle", e_idle());
    run_instr("wrap", 4'b0011, 0, 3'b001, 1'b0, 1'b1);
    check("wrap_cnt", {16'd0, instr_count}, 32'd0);

    // reset asserted in the middle of WB
    op       = 4'b0010;
    imem_ack = 1'b1;
    step("midwb_fetch", e_fetch(1'b1));
    step("midwb_decode", e_dec());
    step("midwb_exec", e_exec(3'b000, 1'b0));
    check("midwb_state", {29'd0, state}, 32'd4);
    apply_reset("rst_midwb");

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
